// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the instruction-fetch stage.
//   fetch_state_e : fetch FSM state encoding (FETCH, HOLD)
//   NOP_INSTR     : instruction word placed into IF/ID for a bubble
//   RESET_PC      : reset value of the upstream PC register; the fetch stage
//                   itself does not use it
//   PERF_W_DEFAULT: default width of the fetch-wait counter
//   pc_plus4()    : modulo-2^32 PC increment
package cpu_pkg;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;
  localparam logic [31:0] RESET_PC       = 32'h0040_0030;
  localparam int          PERF_W_DEFAULT = 16;

  // Wraps naturally: 32'hFFFF_FFFC + 4 gives 32'h0000_0000.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// fetch_hold_buf: one-entry buffer holding {instruction, PC+4} for a word that
// was acknowledged while decode was stalled.
//   clk     in  clock
//   reset   in  asynchronous active-high reset (contents cleared)
//   load_i  in  capture data_i
//   clear_i in  drop the contents; wins over load_i
//   data_i  in  {instr[31:0], pc_plus4[31:0]}
//   data_o  out registered contents
module fetch_hold_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic [63:0] data_i,
  output logic [63:0] data_o
);

  logic [63:0] data_q;

  // Buffer storage: clear has priority over load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= 64'h0;
    end else if (clear_i) begin
      data_q <= 64'h0;
    end else if (load_i) begin
      data_q <= data_i;
    end else begin
      data_q <= data_q;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction fetch with req/ack memory handshake, IF/ID
// pipeline register, one-entry hold buffer and a saturating fetch-wait counter.
//   clk, reset    clock, asynchronous active-high reset
//   PCF           current fetch PC
//   StallD        hold IF/ID
//   FlushD        clear IF/ID (priority over StallD)
//   imem_req/addr fetch request and address (addr = PCF)
//   imem_ack/rdata memory response for the current address
//   InstrD, PCPlus4D, ValidD  IF/ID register outputs
//   FetchBusy     freezes the PC while the fetch cannot advance
//   FetchWaitCnt  saturating count of cycles with req && !ack
module if_fetch_stage #(
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       PCF,
  input  logic              StallD,
  input  logic              FlushD,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       InstrD,
  output logic [31:0]       PCPlus4D,
  output logic              ValidD,
  output logic              FetchBusy,
  output logic [PERF_W-1:0] FetchWaitCnt
);

  import cpu_pkg::*;

  fetch_state_e      state_q, state_d;
  logic [31:0]       instr_q, instr_d;
  logic [31:0]       pc4_q, pc4_d;
  logic              valid_q, valid_d;
  logic [PERF_W-1:0] wait_cnt_q, wait_cnt_d;
  // Low from reset until the first edge after release, so no request is
  // issued in the partial cycle right after reset drops.
  logic              run_q;
  logic              req_s;
  logic              buf_load_s, buf_clear_s;
  logic [63:0]       buf_data_s;

  fetch_hold_buf u_hold_buf (
    .clk     (clk),
    .reset   (reset),
    .load_i  (buf_load_s),
    .clear_i (buf_clear_s),
    .data_i  ({imem_rdata, pc_plus4(PCF)}),
    .data_o  (buf_data_s)
  );

  assign req_s     = run_q && (state_q == FETCH);
  assign imem_req  = req_s;
  assign imem_addr = PCF;
  assign FetchBusy = run_q && ((state_q == HOLD) || !imem_ack);

  assign InstrD       = instr_q;
  assign PCPlus4D     = pc4_q;
  assign ValidD       = valid_q;
  assign FetchWaitCnt = wait_cnt_q;

  // Next-state logic for the FSM, IF/ID register, hold buffer and counter.
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    pc4_d       = pc4_q;
    valid_d     = valid_q;
    buf_load_s  = 1'b0;
    buf_clear_s = 1'b0;

    if (req_s && !imem_ack && (wait_cnt_q != {PERF_W{1'b1}})) begin
      wait_cnt_d = wait_cnt_q + PERF_W'(1);
    end else begin
      wait_cnt_d = wait_cnt_q;
    end

    if (!run_q) begin
      state_d = FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          if (FlushD) begin
            instr_d = NOP_INSTR;
            pc4_d   = 32'h0;
            valid_d = 1'b0;
          end else if (imem_ack) begin
            if (StallD) begin
              // Decode cannot take the word yet; park it.
              buf_load_s = 1'b1;
              state_d    = HOLD;
            end else begin
              instr_d = imem_rdata;
              pc4_d   = pc_plus4(PCF);
              valid_d = 1'b1;
            end
          end else begin
            if (!StallD) begin
              // Memory still busy: push a bubble, keep PCPlus4D.
              instr_d = NOP_INSTR;
              valid_d = 1'b0;
            end else begin
              valid_d = valid_q;
            end
          end
        end
        HOLD: begin
          if (FlushD) begin
            instr_d     = NOP_INSTR;
            pc4_d       = 32'h0;
            valid_d     = 1'b0;
            buf_clear_s = 1'b1;
            state_d     = FETCH;
          end else if (!StallD) begin
            instr_d = buf_data_s[63:32];
            pc4_d   = buf_data_s[31:0];
            valid_d = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = HOLD;
          end
        end
        default: begin
          state_d = FETCH;
        end
      endcase
    end
  end

  // State, IF/ID and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= FETCH;
      instr_q    <= NOP_INSTR;
      pc4_q      <= 32'h0;
      valid_q    <= 1'b0;
      wait_cnt_q <= {PERF_W{1'b0}};
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      pc4_q      <= pc4_d;
      valid_q    <= valid_d;
      wait_cnt_q <= wait_cnt_d;
      run_q      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PCF;
  logic        StallD, FlushD;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] InstrD, PCPlus4D;
  logic        ValidD, FetchBusy;
  logic [15:0] FetchWaitCnt;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: IF/ID contents, parked words, wait counter.
  logic [31:0] m_instr, m_pc4;
  logic        m_valid;
  int          m_cnt;
  bit          m_armed;
  logic [63:0] m_park[$];

  if_fetch_stage #(.PERF_W(16)) dut (
    .clk(clk), .reset(reset), .PCF(PCF), .StallD(StallD), .FlushD(FlushD),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .InstrD(InstrD), .PCPlus4D(PCPlus4D),
    .ValidD(ValidD), .FetchBusy(FetchBusy), .FetchWaitCnt(FetchWaitCnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    return {pc[15:0], ~pc[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_instr"}, InstrD, m_instr);
    chk({tag, "_pc4"}, PCPlus4D, m_pc4);
    chk({tag, "_valid"}, ValidD, m_valid);
    chk({tag, "_cnt"}, FetchWaitCnt, m_cnt);
  endtask

  task automatic model_reset();
    m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_cnt = 0;
    m_armed = 1'b0; m_park.delete();
  endtask

  // One clock edge of the reference behaviour.
  task automatic model_edge(input logic st, input logic fl, input logic ak,
                            input logic [31:0] pc, input logic [31:0] rd);
    logic [63:0] e;
    if (!m_armed) begin
      m_armed = 1'b1;
    end else if (m_park.size() == 0) begin
      if (!ak && m_cnt < 65535) m_cnt++;
      if (fl) begin
        m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      end else if (ak && !st) begin
        m_instr = rd; m_pc4 = pc + 32'd4; m_valid = 1'b1;
      end else if (ak && st) begin
        m_park.push_back({rd, pc + 32'd4});
      end else if (!st) begin
        m_instr = 32'h0; m_valid = 1'b0;
      end
    end else begin
      if (fl) begin
        m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_park.delete();
      end else if (!st) begin
        e = m_park.pop_front();
        m_instr = e[63:32]; m_pc4 = e[31:0]; m_valid = 1'b1;
      end
    end
  endtask

  // Called at a negative edge: drive, check combinational outputs, clock, check registers.
  task automatic step(input logic st, input logic fl, input logic ak,
                      input logic [31:0] pc, input bit do_chk);
    logic [31:0] rd;
    rd = mem_word(pc);
    StallD = st; FlushD = fl; imem_ack = ak; PCF = pc; imem_rdata = rd;
    #1;
    if (do_chk) begin
      chk("req", imem_req, m_armed && (m_park.size() == 0));
      chk("busy", FetchBusy, m_armed && ((m_park.size() != 0) || !ak));
      chk("addr", imem_addr, pc);
    end
    @(posedge clk);
    model_edge(st, fl, ak, pc, rd);
    #1;
    if (do_chk) chk_regs("reg");
    @(negedge clk);
  endtask

  // Asynchronous reset pulse spanning one rising edge; returns at a negedge, reset low.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk_regs("rst_async");
    chk("rst_req", imem_req, 1'b0);
    chk("rst_busy", FetchBusy, 1'b0);
    @(posedge clk);
    #1;
    chk("rst_req_hold", imem_req, 1'b0);
    chk_regs("rst_hold");
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; PCF = 32'h0; StallD = 1'b0; FlushD = 1'b0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    model_reset();
    @(negedge clk);
    do_reset();

    // First edge after release only arms the stage.
    step(1'b0, 1'b0, 1'b1, cpu_pkg::RESET_PC, 1'b1);
    step(1'b0, 1'b0, 1'b1, cpu_pkg::RESET_PC, 1'b1);
    chk("t1_instr", InstrD, mem_word(32'h0040_0030));
    chk("t1_pc4", PCPlus4D, 32'h0040_0034);
    chk("t1_valid", ValidD, 1'b1);

    // Three wait cycles, then ack.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0040_0034, 1'b1);
      chk("t2_bubble", ValidD, 1'b0);
    end
    chk("t2_cnt", FetchWaitCnt, 16'd3);
    step(1'b0, 1'b0, 1'b1, 32'h0040_0034, 1'b1);
    chk("t2_instr", InstrD, mem_word(32'h0040_0034));

    // Stall coincident with ack: word parked, released when stall drops.
    step(1'b1, 1'b0, 1'b1, 32'h0040_0038, 1'b1);
    chk("t3_old", InstrD, mem_word(32'h0040_0034));
    step(1'b1, 1'b0, 1'b0, 32'h0040_003C, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0040_003C, 1'b1);
    chk("t3_buf", InstrD, mem_word(32'h0040_0038));
    chk("t3_pc4", PCPlus4D, 32'h0040_003C);
    step(1'b0, 1'b0, 1'b1, 32'h0040_003C, 1'b1);
    chk("t3_next", InstrD, mem_word(32'h0040_003C));

    // Flush with stall while holding.
    step(1'b1, 1'b0, 1'b1, 32'h0040_0040, 1'b1);
    step(1'b1, 1'b1, 1'b0, 32'h0040_0044, 1'b1);
    chk("t4_valid", ValidD, 1'b0);
    chk("t4_instr", InstrD, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h0040_0080, 1'b1);
    chk("t4_refetch", InstrD, mem_word(32'h0040_0080));

    // PC+4 wrap.
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    chk("t5_wrap", PCPlus4D, 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 3), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 9) < 6), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, 1'b1);
    end

    // Reset in the middle of a wait.
    step(1'b0, 1'b0, 1'b0, 32'h0040_0100, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0040_0100, 1'b1);
    do_reset();
    step(1'b0, 1'b0, 1'b1, cpu_pkg::RESET_PC, 1'b1);
    step(1'b0, 1'b0, 1'b1, cpu_pkg::RESET_PC, 1'b1);

    // Reset in the middle of a hold.
    step(1'b1, 1'b0, 1'b1, 32'h0040_0034, 1'b1);
    do_reset();
    step(1'b0, 1'b0, 1'b0, cpu_pkg::RESET_PC, 1'b1);

    // Counter saturation.
    for (int i = 0; i < 65540; i++) begin
      step(1'b0, 1'b0, 1'b0, cpu_pkg::RESET_PC, 1'b0);
    end
    step(1'b0, 1'b0, 1'b0, cpu_pkg::RESET_PC, 1'b1);
    chk("t6_sat", FetchWaitCnt, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
